optical_transmitter: RTL and testbench

// - Serialises bytes onto the 8-bit optical sample bus: each clock emits 8'hFF (light ON) or 8'h00 (light OFF).
// - Pulse-width line code: every symbol is one ON pulse followed by an OFF gap; pulse length selects START / bit 0 / bit 1.
// - Transmit end of the optical link; the far-end receiver segments the line into ON/OFF runs and measures run lengths.
// - Upstream source hands bytes in via a valid/ready handshake; one byte per frame.

---
 rtl/optical_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_optical_transmitter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/optical_transmitter.sv
// optical_transmitter: pulse-width line-code serialiser for an 8-bit optical sample bus.
// Each frame is a START pulse, then 8 data symbols MSB first; every pulse is followed by an
// OFF gap. A data bit of 1 gives a LONG pulse and a data bit of 0 gives a SHORT pulse.
// Optional feature macro: OPTICAL_TX_PARITY_EN appends one even-parity symbol after bit 0.
module optical_transmitter #(
    parameter int unsigned SHORT_CYCLES = 4,
    parameter int unsigned LONG_CYCLES  = 8,
    parameter int unsigned START_CYCLES = 16,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_din,
    input  logic       i_vin,
    output logic       o_ready,
    output logic [7:0] o_dout,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStartOn,
        StStartGap,
        StBitOn,
`ifdef OPTICAL_TX_PARITY_EN
        StParOn,
        StParGap,
`endif
        StBitGap
    } state_e;

    localparam logic [8:0] LdShort = 9'(SHORT_CYCLES - 1);
    localparam logic [8:0] LdLong  = 9'(LONG_CYCLES - 1);
    localparam logic [8:0] LdStart = 9'(START_CYCLES - 1);
    localparam logic [8:0] LdGap   = 9'(GAP_CYCLES - 1);

    state_e     r_state, w_state_d;
    logic [8:0] r_cnt, w_cnt_d;
    logic [2:0] r_bit_idx, w_bit_idx_d;
    logic [7:0] r_shift, w_shift_d;
    logic [7:0] r_dout;
    logic       w_on;
`ifdef OPTICAL_TX_PARITY_EN
    logic       r_par, w_par_d;
`endif

    // Counter reload value for an ON pulse carrying the given symbol value.
    function automatic logic [8:0] pulse_ld(input logic b);
        return b ? LdLong : LdShort;
    endfunction

    // State, run counter and byte registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= 9'd0;
            r_bit_idx <= 3'd7;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_bit_idx <= w_bit_idx_d;
            r_shift   <= w_shift_d;
        end
    end

`ifdef OPTICAL_TX_PARITY_EN
    // Parity of the accepted byte, held for the trailing parity symbol.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_par <= 1'b0;
        else       r_par <= w_par_d;
    end
`endif

    // Next-state logic: the counter is loaded with length-1 on entry and the state
    // advances on the cycle it reads zero, so every run is exactly its nominal length.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_bit_idx_d = r_bit_idx;
        w_shift_d   = r_shift;
`ifdef OPTICAL_TX_PARITY_EN
        w_par_d     = r_par;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_vin) begin
                    w_state_d   = StStartOn;
                    w_cnt_d     = LdStart;
                    w_shift_d   = i_din;
                    w_bit_idx_d = 3'd7;
`ifdef OPTICAL_TX_PARITY_EN
                    w_par_d     = ^i_din;
`endif
                end
            end
            StStartOn: begin
                if (r_cnt == 9'd0) begin
                    w_state_d = StStartGap;
                    w_cnt_d   = LdGap;
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
            StStartGap: begin
                if (r_cnt == 9'd0) begin
                    w_state_d = StBitOn;
                    w_cnt_d   = pulse_ld(r_shift[r_bit_idx]);
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
            StBitOn: begin
                if (r_cnt == 9'd0) begin
                    w_state_d = StBitGap;
                    w_cnt_d   = LdGap;
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
            StBitGap: begin
                if (r_cnt == 9'd0) begin
                    if (r_bit_idx == 3'd0) begin
`ifdef OPTICAL_TX_PARITY_EN
                        w_state_d = StParOn;
                        w_cnt_d   = pulse_ld(r_par);
`else
                        w_state_d = StIdle;
                        w_cnt_d   = 9'd0;
`endif
                    end else begin
                        w_state_d   = StBitOn;
                        w_bit_idx_d = r_bit_idx - 3'd1;
                        w_cnt_d     = pulse_ld(r_shift[r_bit_idx - 3'd1]);
                    end
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
`ifdef OPTICAL_TX_PARITY_EN
            StParOn: begin
                if (r_cnt == 9'd0) begin
                    w_state_d = StParGap;
                    w_cnt_d   = LdGap;
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
            StParGap: begin
                if (r_cnt == 9'd0) begin
                    w_state_d = StIdle;
                    w_cnt_d   = 9'd0;
                end else begin
                    w_cnt_d = r_cnt - 9'd1;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = 9'd0;
            end
        endcase
    end

    // Light is on whenever the next state is a pulse state.
    always_comb begin
        w_on = (w_state_d == StStartOn) || (w_state_d == StBitOn)
`ifdef OPTICAL_TX_PARITY_EN
            || (w_state_d == StParOn)
`endif
            ;
    end

    // Registered optical output, aligned with the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_dout <= 8'h00;
        else       r_dout <= w_on ? 8'hFF : 8'h00;
    end

    assign o_dout  = r_dout;
    assign o_ready = (r_state == StIdle);
    assign o_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_optical_transmitter.sv
// Self-checking bench for optical_transmitter: directed and random bytes against a
// reference model that expands each byte into its expected ON/OFF sample stream.
module tb_optical_transmitter;

    localparam int SHORT = 4;
    localparam int LONG  = 8;
    localparam int START = 16;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vin = 1'b0;
    logic       ready;
    logic [7:0] dout;
    logic       busy;

    int n_vec  = 0;
    int n_fail = 0;
    bit exp_q[$];

    optical_transmitter #(
        .SHORT_CYCLES(SHORT),
        .LONG_CYCLES (LONG),
        .START_CYCLES(START),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_din  (din),
        .i_vin  (vin),
        .o_ready(ready),
        .o_dout (dout),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected line samples for one frame, 1 = light on.
    task automatic build(input logic [7:0] b);
        bit bitv;
        exp_q.delete();
        repeat (START) exp_q.push_back(1'b1);
        repeat (GAP) exp_q.push_back(1'b0);
        for (int k = 7; k >= 0; k--) begin
            bitv = b[k];
            repeat (bitv ? LONG : SHORT) exp_q.push_back(1'b1);
            repeat (GAP) exp_q.push_back(1'b0);
        end
`ifdef OPTICAL_TX_PARITY_EN
        bitv = ^b;
        repeat (bitv ? LONG : SHORT) exp_q.push_back(1'b1);
        repeat (GAP) exp_q.push_back(1'b0);
`endif
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_dout"}, dout, 8'h00);
            chk({tag, "_ready"}, {7'd0, ready}, 8'd1);
            tick();
        end
    endtask

    // Offer byte b, follow the whole frame, and finish in the first IDLE cycle.
    // pulse_at >= 0 pulses vin with 0x3C mid-frame; abort_at >= 0 resets mid-frame.
    task automatic frame(input logic [7:0] b, input logic next_v, input logic [7:0] next_b,
                         input int pulse_at, input int abort_at);
        build(b);
        din = b;
        vin = 1'b1;
        chk("accept_ready", {7'd0, ready}, 8'd1);
        tick();
        vin = next_v;
        din = next_b;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("frame_dout", dout, exp_q[i] ? 8'hFF : 8'h00);
            chk("frame_busy", {6'd0, busy, ready}, 8'b10);
            if (i == pulse_at) begin
                vin = 1'b1;
                din = 8'h3C;
            end else if (i == pulse_at + 1) begin
                vin = next_v;
                din = next_b;
            end
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            tick();
        end
        chk("end_dout", dout, 8'h00);
        chk("end_ready", {7'd0, ready}, 8'd1);
    endtask

    initial begin
        int idx;
        logic [7:0] rb;
        // Reset and idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {7'd0, busy}, 8'd0);
        idle_check(20, "idle");

        // Single 0xA5 frame
        frame(8'hA5, 1'b0, 8'h00, -1, -1);
        idle_check(3, "post_a5");

        // Back-to-back 0x00 then 0xFF, vin held high
        frame(8'h00, 1'b1, 8'hFF, -1, -1);
        frame(8'hFF, 1'b0, 8'h00, -1, -1);
        idle_check(3, "post_b2b");

        // vin pulsed with 0x3C while busy must be ignored
        frame(8'h5A, 1'b0, 8'h00, 30, -1);
        idle_check(40, "no_second");

        // Reset midway through bit 3 pulse of 0xFF
        idx = START + GAP + 4 * (LONG + GAP) + LONG / 2;
        frame(8'hFF, 1'b0, 8'h00, -1, idx);
        idle_check(40, "after_abort");

        // Parity-relevant bytes (also valid without parity)
        frame(8'h07, 1'b0, 8'h00, -1, -1);
        idle_check(2, "post_07");
        frame(8'h03, 1'b0, 8'h00, -1, -1);
        idle_check(2, "post_03");

        // Random bytes, random back-to-back or idle spacing
        rb = 8'($urandom);
        for (int n = 0; n < 8; n++) begin
            logic [7:0] nb;
            logic       b2b;
            nb  = 8'($urandom);
            b2b = 1'($urandom_range(0, 1));
            frame(rb, b2b, nb, -1, -1);
            if (!b2b) begin
                vin = 1'b0;
                idle_check(int'($urandom_range(1, 5)), "rand_gap");
            end
            rb = nb;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
